// File: rtl/fft256_pkg.sv
// Shared constants, FSM state encoding, bus payload types and address
// helpers for the 256-point in-place radix-2 FFT sequencer.
package fft256_pkg;

  localparam int unsigned N    = 256;
  localparam int unsigned LOGN = 8;
  localparam int unsigned SW   = 3;        // stage index width, log2(LOGN)
  localparam int unsigned JW   = LOGN - 1; // butterfly index width, log2(N/2)

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CALC  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_OUT   = 3'd4
  } state_e;

  // Butterfly read-side addressing for one (stage, j) pair.
  typedef struct packed {
    logic [LOGN-1:0] a;
    logic [LOGN-1:0] b;
    logic [LOGN-2:0] tw;
  } bf_addr_t;

  // One slot of the write-back delay line.
  typedef struct packed {
    logic            en;
    logic [LOGN-1:0] a;
    logic [LOGN-1:0] b;
  } wb_slot_t;

  // Mirror the LOGN address bits.
  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] x);
    logic [LOGN-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < LOGN; i++) begin
      r[i] = x[LOGN-1-i];
    end
    return r;
  endfunction

  // Insert a zero at bit 'stage' of j to get the upper operand; the lower
  // operand sits one span above it. Twiddle index scales the in-group offset.
  function automatic bf_addr_t bf_addr(input logic [SW-1:0] stage,
                                       input logic [JW-1:0] j);
    logic [LOGN-1:0] jj;
    logic [LOGN-1:0] span;
    logic [LOGN-1:0] lo;
    bf_addr_t        r;
    jj   = LOGN'(j);
    span = LOGN'(1) << stage;
    lo   = jj & (span - LOGN'(1));
    r.a  = ((jj >> stage) << (32'(stage) + 32'd1)) | lo;
    r.b  = r.a + span;
    r.tw = (LOGN-1)'(lo << (32'(LOGN - 1) - 32'(stage)));
    return r;
  endfunction

endpackage

// File: rtl/fft_bf_addr_gen.sv
// Registered butterfly address generator plus the write-back delay line.
// Ports: clk/rst_n; issue_i, stage_i, j_i from the sequencer FSM;
// bf_rd_en_o/bf_addr_a_o/bf_addr_b_o/tw_addr_o one cycle after issue;
// wb_en_o/wb_addr_a_o/wb_addr_b_o the read-side values BF_LAT cycles later.
module fft_bf_addr_gen
  import fft256_pkg::*;
#(
  parameter int unsigned BF_LAT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_i,
  input  logic [SW-1:0]   stage_i,
  input  logic [JW-1:0]   j_i,
  output logic            bf_rd_en_o,
  output logic [LOGN-1:0] bf_addr_a_o,
  output logic [LOGN-1:0] bf_addr_b_o,
  output logic [LOGN-2:0] tw_addr_o,
  output logic            wb_en_o,
  output logic [LOGN-1:0] wb_addr_a_o,
  output logic [LOGN-1:0] wb_addr_b_o
);

  bf_addr_t addr_c;
  bf_addr_t rd_q;
  logic     rd_en_q;
  wb_slot_t dly_q [BF_LAT];

  assign addr_c = bf_addr(stage_i, j_i);

  // Read-side register; addresses read as zero when no butterfly is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_q <= 1'b0;
      rd_q    <= '0;
    end else begin
      rd_en_q <= issue_i;
      rd_q    <= issue_i ? addr_c : '0;
    end
  end

  // Write-back delay line, squashed by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < BF_LAT; k++) dly_q[k] <= '0;
    end else begin
      dly_q[0] <= '{en: rd_en_q, a: rd_q.a, b: rd_q.b};
      for (int unsigned k = 1; k < BF_LAT; k++) dly_q[k] <= dly_q[k-1];
    end
  end

  assign bf_rd_en_o  = rd_en_q;
  assign bf_addr_a_o = rd_q.a;
  assign bf_addr_b_o = rd_q.b;
  assign tw_addr_o   = rd_q.tw;
  assign wb_en_o     = dly_q[BF_LAT-1].en;
  assign wb_addr_a_o = dly_q[BF_LAT-1].a;
  assign wb_addr_b_o = dly_q[BF_LAT-1].b;

endmodule

// File: rtl/fft256_seq_ctrl.sv
// Frame sequencer for the in-place 256-point radix-2 FFT: bit-reversed load,
// 8 x 128 butterfly address issue with drain gaps, natural-order readout.
// Ports: clk/rst_n; valid_in_i/sop_in_i/inv_in_i input stream; wr_en_o/
// wr_addr_o load writes; bf_*/tw_*/wb_* butterfly control; out_rd_addr_o,
// valid_out_o, sop_out_o result stream; busy_o, drop_err_o status.
module fft256_seq_ctrl
  import fft256_pkg::*;
#(
  parameter int unsigned BF_LAT = 4,
  parameter int unsigned RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_in_i,
  input  logic            sop_in_i,
  input  logic            inv_in_i,
  output logic            wr_en_o,
  output logic [LOGN-1:0] wr_addr_o,
  output logic            bf_rd_en_o,
  output logic [LOGN-1:0] bf_addr_a_o,
  output logic [LOGN-1:0] bf_addr_b_o,
  output logic [LOGN-2:0] tw_addr_o,
  output logic            tw_conj_o,
  output logic            wb_en_o,
  output logic [LOGN-1:0] wb_addr_a_o,
  output logic [LOGN-1:0] wb_addr_b_o,
  output logic [LOGN-1:0] out_rd_addr_o,
  output logic            valid_out_o,
  output logic            sop_out_o,
  output logic            busy_o,
  output logic            drop_err_o
);

  localparam int unsigned DW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

  state_e          state_q, state_d;
  logic [LOGN-1:0] cnt_q, cnt_d;
  logic [LOGN-1:0] out_cnt_q, out_cnt_d;
  logic [SW-1:0]   stage_q, stage_d;
  logic [JW-1:0]   j_q, j_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic            inv_q, inv_d;
  logic            wr_en_q, wr_en_d;
  logic [LOGN-1:0] wr_addr_q, wr_addr_d;
  logic            out_iss_q, out_iss_d;
  logic            out_sop_q, out_sop_d;
  logic [LOGN-1:0] out_addr_q, out_addr_d;
  logic            drop_q, drop_d;
  logic            busy_q;
  logic            bf_issue;
  logic [RD_LAT-1:0] vo_pipe_q, sop_pipe_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (valid_in_i && sop_in_i) state_d = ST_LOAD;
      ST_LOAD:  if (valid_in_i && !sop_in_i && cnt_q == LOGN'(N - 1)) state_d = ST_CALC;
      ST_CALC:  if (j_q == JW'(N / 2 - 1)) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_q == DW'(BF_LAT - 1))
                  state_d = (stage_q == SW'(LOGN - 1)) ? ST_OUT : ST_CALC;
      ST_OUT:   if (out_cnt_q == LOGN'(N - 1)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Counter updates and next values of the registered strobes.
  always_comb begin
    cnt_d      = cnt_q;
    out_cnt_d  = out_cnt_q;
    stage_d    = stage_q;
    j_d        = j_q;
    drain_d    = drain_q;
    inv_d      = inv_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = '0;
    out_iss_d  = 1'b0;
    out_sop_d  = 1'b0;
    out_addr_d = '0;
    drop_d     = 1'b0;
    bf_issue   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (valid_in_i && sop_in_i) begin
          wr_en_d = 1'b1;
          inv_d   = inv_in_i;
          cnt_d   = LOGN'(1);
        end
      end
      ST_LOAD: begin
        if (valid_in_i) begin
          wr_en_d = 1'b1;
          if (sop_in_i) begin
            // Restart: index 0 is written again, direction re-sampled.
            inv_d = inv_in_i;
            cnt_d = LOGN'(1);
          end else begin
            wr_addr_d = bitrev(cnt_q);
            cnt_d     = cnt_q + LOGN'(1);
            if (cnt_q == LOGN'(N - 1)) begin
              stage_d = '0;
              j_d     = '0;
            end
          end
        end
      end
      ST_CALC: begin
        bf_issue = 1'b1;
        drop_d   = valid_in_i;
        j_d      = j_q + JW'(1);
        drain_d  = '0;
      end
      ST_DRAIN: begin
        drop_d  = valid_in_i;
        drain_d = drain_q + DW'(1);
        if (drain_q == DW'(BF_LAT - 1)) begin
          drain_d   = '0;
          stage_d   = stage_q + SW'(1);
          out_cnt_d = '0;
        end
      end
      ST_OUT: begin
        drop_d     = valid_in_i;
        out_iss_d  = 1'b1;
        out_addr_d = out_cnt_q;
        out_sop_d  = (out_cnt_q == '0);
        out_cnt_d  = out_cnt_q + LOGN'(1);
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      out_cnt_q  <= '0;
      stage_q    <= '0;
      j_q        <= '0;
      drain_q    <= '0;
      inv_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      out_iss_q  <= 1'b0;
      out_sop_q  <= 1'b0;
      out_addr_q <= '0;
      drop_q     <= 1'b0;
      busy_q     <= 1'b0;
      vo_pipe_q  <= '0;
      sop_pipe_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      out_cnt_q  <= out_cnt_d;
      stage_q    <= stage_d;
      j_q        <= j_d;
      drain_q    <= drain_d;
      inv_q      <= inv_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      out_iss_q  <= out_iss_d;
      out_sop_q  <= out_sop_d;
      out_addr_q <= out_addr_d;
      drop_q     <= drop_d;
      busy_q     <= (state_d != ST_IDLE);
      // RAM read latency alignment for the output strobes.
      vo_pipe_q[0]  <= out_iss_q;
      sop_pipe_q[0] <= out_sop_q;
      for (int unsigned k = 1; k < RD_LAT; k++) begin
        vo_pipe_q[k]  <= vo_pipe_q[k-1];
        sop_pipe_q[k] <= sop_pipe_q[k-1];
      end
    end
  end

  fft_bf_addr_gen #(.BF_LAT(BF_LAT)) u_addr_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_i     (bf_issue),
    .stage_i     (stage_q),
    .j_i         (j_q),
    .bf_rd_en_o  (bf_rd_en_o),
    .bf_addr_a_o (bf_addr_a_o),
    .bf_addr_b_o (bf_addr_b_o),
    .tw_addr_o   (tw_addr_o),
    .wb_en_o     (wb_en_o),
    .wb_addr_a_o (wb_addr_a_o),
    .wb_addr_b_o (wb_addr_b_o)
  );

  assign wr_en_o       = wr_en_q;
  assign wr_addr_o     = wr_addr_q;
  assign tw_conj_o     = inv_q;
  assign out_rd_addr_o = out_addr_q;
  assign valid_out_o   = vo_pipe_q[RD_LAT-1];
  assign sop_out_o     = sop_pipe_q[RD_LAT-1];
  assign busy_o        = busy_q;
  assign drop_err_o    = drop_q;

endmodule
